// File: rtl/uart_rx_os16_if.sv
// rtl/uart_rx_os16_if.sv - serial line and received-byte bundle for uart_rx_os16
interface uart_rx_os16_if;
    logic       rx;
    logic [7:0] RxData;
    logic       valid_rx;
    logic       frame_err;
    logic       busy_rx;

    modport master (
        input  rx,
        output RxData,
        output valid_rx,
        output frame_err,
        output busy_rx
    );

    modport slave (
        output rx,
        input  RxData,
        input  valid_rx,
        input  frame_err,
        input  busy_rx
    );
endinterface

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling 8N1 UART receiver with mid-bit sampling
module uart_rx_os16 #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_os16_if.master  bus
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("uart_rx_os16: DIV must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [1:0]      rx_sync;
    logic            rx_s;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [3:0]      sample_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic [7:0]      rx_data_q;
    logic            valid_q;
    logic            frame_err_q;
    logic            shift_en;
    logic            load_en;
    logic            err_en;
    logic            busy;

    assign rx_s = rx_sync[1];
    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], bus.rx};
        end
    end

    // Held at zero while waiting for a start edge so START always begins phase-aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (state == S_IDLE || state == S_WAIT_HIGH || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
        end else if (next_state != state) begin
            sample_cnt <= '0;
        end else if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) next_state = S_START;
            end
            S_START: begin
                if (tick && sample_cnt == 4'd7) next_state = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && sample_cnt == 4'd15 && bit_idx == 3'd7) next_state = S_STOP;
            end
            S_STOP: begin
                if (tick && sample_cnt == 4'd15) next_state = rx_s ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (rx_s) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        load_en  = 1'b0;
        err_en   = 1'b0;
        busy     = (state != S_IDLE);
        if (state == S_DATA && tick && sample_cnt == 4'd15) begin
            shift_en = 1'b1;
        end
        if (state == S_STOP && tick && sample_cnt == 4'd15) begin
            load_en = rx_s;
            err_en  = !rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_idx     <= '0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= load_en;
            frame_err_q <= err_en;
            if (state == S_IDLE) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                bit_idx   <= bit_idx + 1'b1;
            end
            if (load_en) begin
                rx_data_q <= shift_reg;
            end
        end
    end

    assign bus.RxData    = rx_data_q;
    assign bus.valid_rx  = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy_rx   = busy;
endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

Oversampling UART receiver: the far-end counterpart of the byte transmitter driven through `uart_if`. It recovers 8N1 frames from the serial line using a 16x sample tick and mid-bit sampling. Each good byte is presented on `RxData` with a one-cycle `valid_rx` strobe; a bad stop bit is flagged on `frame_err`. It sits beside the transmitter in `Uart_Interface` and runs on the same system clock.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bits/s.
- `DIV`, derived as CLK_FREQ / (BAUD*16), integer floor; elaboration `$error` if DIV < 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line; idles high; asynchronous to `clk`.
- `RxData`  out  8  last correctly received byte; holds until the next good frame.
- `valid_rx`  out  1  one-cycle pulse when `RxData` is updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy_rx`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronizer output, `rx_s`.
- **Tick generator.** A counter of width clog2(DIV) produces `tick` once every DIV clocks. It is held at 0 in IDLE and in WAIT_HIGH, and restarts from 0 on entry to START.
- **Sample counter.** 4 bits, counts ticks; cleared on each state entry and after each data bit.
- **Bit index.** 3 bits.
- **Shift register.** 8 bits; fills LSB first by shifting right, with `rx_s` entering at bit 7.
- **FSM states:**
  - IDLE: `rx_s`==0 -> START.
  - START: on the 8th tick (mid start bit), if `rx_s`==0 -> DATA; if `rx_s`==1 it is a false start -> IDLE, with no output pulse.
  - DATA: on every 16th tick, shift in `rx_s` and increment the bit index. After bit 7 -> STOP.
  - STOP: on the 16th tick:
    - `rx_s`==1: load `RxData` from the shift register, pulse `valid_rx`, go to IDLE.
    - `rx_s`==0: pulse `frame_err`, leave `RxData` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: `rx_s`==1 -> IDLE. A held break therefore produces exactly one `frame_err`.
- `valid_rx` and `frame_err` are mutually exclusive and never high in consecutive cycles.
- No overrun handling: a new frame overwrites `RxData` regardless of whether the consumer has read it.
- **Reset**, asynchronous, effective at any point including mid-frame:
  - FSM -> IDLE.
  - `RxData`=0x00, `valid_rx`=0, `frame_err`=0, `busy_rx`=0.
  - Synchronizer flops = 1.
  - All counters = 0.
  - After release, the first frame is received normally only if its start edge comes after the release. A partial frame that was in flight at reset is discarded.

## Timing
- Let `rx` be low at rising edge N.
  - `rx_s` is low after edge N+1.
  - The FSM enters START at edge N+2, and `busy_rx` rises at N+2.
- Counted from START entry:
  - start check: 8 ticks;
  - data bits: 8x16 ticks;
  - stop bit: 16 ticks;
  - total: 152 ticks = 152*DIV clocks.
- `valid_rx` / `frame_err` are high for exactly the cycle after edge N+2+152*DIV. `busy_rx` falls on that same edge.
- Data bit k is sampled at edge N+2+(24+16k)*DIV.
- A new start bit is detected the cycle after the FSM returns to IDLE. Back-to-back frames with a single stop bit are received without loss.
- Baud mismatch tolerance is at least ±3% because sampling is mid-bit.

## Test plan
- Bench parameters: CLK_FREQ=50_000_000, BAUD=781_250, giving DIV=4 and a 64-clock bit period.
1. **Reset values.** Hold `reset` for 10 cycles -> all outputs 0, `RxData`=0x00, `busy_rx`=0.
2. **Single byte.** Send 0x41 ('A'), line low first seen at edge N -> exactly one `valid_rx` pulse, at the cycle after edge N+610, with `RxData`=0x41. `frame_err` stays 0.
3. **Back-to-back string.** Send "AISHWARYA" with one stop bit and no gaps -> 9 `valid_rx` pulses in order with 0x41,0x49,0x53,0x48,0x57,0x41,0x52,0x59,0x41, spaced 640 clocks apart.
4. **Framing error.** Send 0x55 with the stop bit driven low, then hold the line low for 2000 clocks -> one `frame_err` pulse, no `valid_rx`, `RxData` keeps its previous value, `busy_rx` stays high until the line returns high. A following 0x33 is then received correctly.
5. **False start.** Drive a 20-clock low glitch -> the FSM returns to IDLE at mid-start; no `valid_rx` and no `frame_err`.
6. **Reset mid-frame.** Assert `reset` during bit 4 of 0xA5 -> outputs return to reset values immediately. After release, a fresh 0xC3 is received with `RxData`=0xC3.
